egress_meta_mailbox: RTL and testbench
======================================

Name: egress_meta_mailbox

Overview:
- Producer-side mailbox feeding the software-polled register interface.
- Buffers per-packet metadata words from the egress path in a small FIFO.
- Presents the head entry as a 32-bit word with a valid flag; software reads it by polling.
- Pops the head on the single-cycle acknowledge pulse the register interface raises when software reads the mailbox address.

Parameters:
- DEPTH, 16, number of FIFO entries; power of two, minimum 2.
- DATA_W, 31, metadata payload width; must be at most 31, since bit 31 of the output word is the valid flag.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- meta_valid  in  1  egress offers a metadata word.
- meta_data  in  DATA_W  metadata payload.
- meta_ready  out  1  mailbox can accept; a transfer happens when meta_valid and meta_ready are both high.
- ack_in  in  1  consume request from the register interface; may stay high for multiple cycles.
- mbox_out  out  32  {valid, zero pad, head payload}; drives the interface's read-data source.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky flag: set when meta_valid is high while meta_ready is low.
- stat_drops  out  16  drop counter (optional feature).
- stat_hiwater  out  $clog2(DEPTH)+1  occupancy high-watermark (optional feature).

Behaviour:
- Reset values: mbox_out=0, count=0, overflow=0, stat_drops=0, stat_hiwater=0. meta_ready=1 from the first cycle after reset. Internal ack_q=0.
- Reset mid-operation discards all stored entries. Overflow and the stats registers are cleared.
- meta_ready = !full. It is combinational from the registered count, with no path from ack_in.
  - When full, a push is rejected even if a pop happens in the same cycle.
- Pop condition: ack_in && !ack_q && !empty.
  - ack_q is ack_in registered, so the pop fires only on the rising edge of ack_in.
  - A multi-cycle ack therefore pops exactly one entry.
- Ack while empty is ignored: no underflow, pointers unchanged.
- Push and pop in the same cycle (not full, not empty): count unchanged, both pointers advance.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. full is count==DEPTH; empty is count==0.
- mbox_out is registered. Each cycle it loads the head after that cycle's push/pop:
  - bit31 = !empty_next.
  - bits[DATA_W-1:0] = head payload.
  - bits[30:DATA_W] = 0.
  - When empty_next, the whole word is 0.
- Latency:
  - Push into an empty FIFO at cycle N: mbox_out valid at N+1.
  - Pop at cycle N: next entry (or 0) visible at N+1.
  - Software is guaranteed a stable word between pops.
- overflow is set on meta_valid && !meta_ready. Only reset clears it.
- Storage is an inferred register array. The payload is stored only on a push.

Optional Feature:
- Macro: MBOX_STATS_EN.
- Defined:
  - stat_drops increments on every rejected offer (meta_valid && !meta_ready) and saturates at 16'hFFFF.
  - stat_hiwater holds the maximum of itself and count_next each cycle.
- Undefined: both outputs are tied to 0 and no counter logic is built.
- The port list is identical either way.

Decomposition:
- Package mbox_pkg:
  - MBOX_VALID_BIT = 31.
  - MBOX_WORD_W = 32.
  - Typedef mbox_word_t = logic [31:0].
  - Helper function pack_mbox(valid, payload).
- One sub-module, sync_fifo, parameterised by DEPTH/WIDTH with push, pop, rd_data, count, full, empty.
  - The top level adds ack edge detection, output word packing, the overflow flag and stats.

Test Plan:
- Reset, then idle: mbox_out=0, count=0, meta_ready=1, overflow=0.
- Push payload 31'h0000_00AB at cycle N: mbox_out=32'h8000_00AB at N+1, count=1. Pulse ack_in one cycle: mbox_out=0 next cycle, count=0.
- Push 3 words (1, 2, 3), then hold ack_in high for 4 cycles: exactly one pop, mbox_out=32'h8000_0002, count=2. Drop ack, raise again: mbox_out=32'h8000_0003.
- Fill 16 entries, offer a 17th with ack rising in the same cycle: 17th rejected, meta_ready=0 before the pop, overflow=1, count=15. With MBOX_STATS_EN: stat_drops=1, stat_hiwater=16.
- Ack pulses with FIFO empty: count stays 0, mbox_out stays 0, no pointer movement. Then push 7: mbox_out=32'h8000_0007.
- Fill 5 entries, assert reset for one cycle: count=0, mbox_out=0, overflow=0. Next push is visible correctly with pointers restarted at 0.
- Wrap test: 40 push/pop pairs with incrementing data: output order matches input order across pointer wrap.

Source files
------------

// File: rtl/mbox_pkg.sv
// Shared types and helpers for the egress metadata mailbox: output word layout
// and the packing function that places the valid flag above the payload.
package mbox_pkg;

    localparam int MBOX_WORD_W    = 32;
    localparam int MBOX_VALID_BIT = 31;
    localparam int MBOX_PAYLOAD_W = MBOX_VALID_BIT;
    localparam int MBOX_STAT_W    = 16;

    typedef logic [MBOX_WORD_W-1:0] mbox_word_t;

    // An empty mailbox reads as all zeros so software never sees a stale payload.
    function automatic mbox_word_t pack_mbox(input logic valid,
                                             input logic [MBOX_PAYLOAD_W-1:0] payload);
        return valid ? {1'b1, payload} : '0;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with count-based full/empty; rd_data is the head as it will
// be after this cycle's push/pop so the caller can register it with no extra latency.
module sync_fifo
    import mbox_pkg::*;
#(
    parameter int  DEPTH = 16,
    parameter int  WIDTH = 31,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_next;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        rd_ptr_next = rd_ptr;
        count_next  = count;
        if (do_pop) begin
            rd_ptr_next = rd_ptr + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // A word written this cycle that lands on the new head slot must bypass the array.
    assign rd_data = (do_push && (wr_ptr == rd_ptr_next)) ? wr_data : mem[rd_ptr_next];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
        end
    end

    // NOTE: the storage array is deliberately not reset; count gates every read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/egress_meta_mailbox.sv
// Egress metadata mailbox: FIFO of payloads presented as {valid, pad, payload},
// popped once per rising edge of ack_in. Drop/high-water stats built under MBOX_STATS_EN.
module egress_meta_mailbox
    import mbox_pkg::*;
#(
    parameter int  DEPTH  = 16,
    parameter int  DATA_W = 31,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   meta_valid,
    input  logic [DATA_W-1:0]      meta_data,
    output logic                   meta_ready,
    input  logic                   ack_in,
    output mbox_word_t             mbox_out,
    output logic [CNT_W-1:0]       count,
    output logic                   overflow,
    output logic [MBOX_STAT_W-1:0] stat_drops,
    output logic [CNT_W-1:0]       stat_hiwater
);

    logic              ack_q;
    logic              push;
    logic              pop;
    logic              rejected;
    logic              full;
    logic              empty;
    logic [DATA_W-1:0] head_next;
    logic [CNT_W-1:0]  count_next;

    // meta_ready depends only on the registered count, never on ack_in.
    assign meta_ready = !full;
    assign push       = meta_valid && meta_ready;
    assign rejected   = meta_valid && !meta_ready;
    assign pop        = ack_in && !ack_q && !empty;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .wr_data    (meta_data),
        .rd_data    (head_next),
        .count      (count),
        .count_next (count_next),
        .full       (full),
        .empty      (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q    <= 1'b0;
            mbox_out <= '0;
            overflow <= 1'b0;
        end else begin
            ack_q    <= ack_in;
            mbox_out <= pack_mbox(count_next != '0, MBOX_PAYLOAD_W'(head_next));
            if (rejected) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef MBOX_STATS_EN
    logic [MBOX_STAT_W-1:0] drops_q;
    logic [CNT_W-1:0]       hiwater_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            drops_q   <= '0;
            hiwater_q <= '0;
        end else begin
            if (rejected && (drops_q != '1)) begin
                drops_q <= drops_q + MBOX_STAT_W'(1);
            end
            if (count_next > hiwater_q) begin
                hiwater_q <= count_next;
            end
        end
    end

    assign stat_drops   = drops_q;
    assign stat_hiwater = hiwater_q;
`else
    assign stat_drops   = '0;
    assign stat_hiwater = '0;
`endif

endmodule

// File: tb/tb_egress_meta_mailbox.sv
// Directed bench for egress_meta_mailbox; a queue scoreboard predicts the head
// word, occupancy, overflow and stats after every cycle.
module tb_egress_meta_mailbox;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 31;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              meta_valid;
    logic [DATA_W-1:0] meta_data;
    logic              meta_ready;
    logic              ack_in;
    logic [31:0]       mbox_out;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic [15:0]       stat_drops;
    logic [CNT_W-1:0]  stat_hiwater;

    egress_meta_mailbox #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .meta_valid   (meta_valid),
        .meta_data    (meta_data),
        .meta_ready   (meta_ready),
        .ack_in       (ack_in),
        .mbox_out     (mbox_out),
        .count        (count),
        .overflow     (overflow),
        .stat_drops   (stat_drops),
        .stat_hiwater (stat_hiwater)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] model_q[$];
    logic              m_ack_prev = 1'b0;
    logic              m_ovf      = 1'b0;
    logic [15:0]       m_drops    = '0;
    int                m_hw       = 0;
    int                n_pass     = 0;
    int                n_total    = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_total++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    // Drive one cycle of stimulus, update the scoreboard from pre-edge state, then land #1 after the edge.
    task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic a);
        logic m_full;
        logic m_empty;
        meta_valid = v;
        meta_data  = d;
        ack_in     = a;
        m_full  = (model_q.size() == DEPTH);
        m_empty = (model_q.size() == 0);
        if (reset) begin
            model_q.delete();
            m_ack_prev = 1'b0;
            m_ovf      = 1'b0;
            m_drops    = '0;
            m_hw       = 0;
        end else begin
            if (v && m_full) begin
                m_ovf = 1'b1;
                if (m_drops != 16'hFFFF) m_drops++;
            end
            if (a && !m_ack_prev && !m_empty) void'(model_q.pop_front());
            if (v && !m_full) model_q.push_back(d);
            m_ack_prev = a;
            if (model_q.size() > m_hw) m_hw = model_q.size();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        logic [31:0] exp_word;
        exp_word = (model_q.size() != 0) ? {1'b1, model_q[0]} : 32'h0;
        check({tag, ".mbox"}, mbox_out, exp_word);
        check({tag, ".count"}, 32'(count), 32'(model_q.size()));
        check({tag, ".ready"}, 32'(meta_ready), 32'(model_q.size() < DEPTH));
        check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
`ifdef MBOX_STATS_EN
        check({tag, ".drops"}, 32'(stat_drops), 32'(m_drops));
        check({tag, ".hiwater"}, 32'(stat_hiwater), 32'(m_hw));
`else
        check({tag, ".drops"}, 32'(stat_drops), 32'h0);
        check({tag, ".hiwater"}, 32'(stat_hiwater), 32'h0);
`endif
    endtask

    initial begin
        reset      = 1'b1;
        meta_valid = 1'b0;
        meta_data  = '0;
        ack_in     = 1'b0;
        cycle(0, '0, 0);
        cycle(0, '0, 0);
        reset = 1'b0;

        // Reset and idle
        cycle(0, '0, 0);
        check("rst.mbox", mbox_out, 32'h0);
        check("rst.count", 32'(count), 32'h0);
        check("rst.ready", 32'(meta_ready), 32'h1);
        check("rst.ovf", 32'(overflow), 32'h0);
        check_state("idle");

        // Single push then single-cycle ack
        cycle(1, 31'h0000_00AB, 0);
        check("push1.mbox", mbox_out, 32'h8000_00AB);
        check("push1.count", 32'(count), 32'h1);
        cycle(0, '0, 1);
        check("pop1.mbox", mbox_out, 32'h0);
        check("pop1.count", 32'(count), 32'h0);
        cycle(0, '0, 0);

        // Long ack pops exactly one
        for (int i = 1; i <= 3; i++) begin
            cycle(1, DATA_W'(i), 0);
            check_state("push3");
        end
        for (int i = 0; i < 4; i++) begin
            cycle(0, '0, 1);
            check_state("longack");
        end
        check("longack.mbox", mbox_out, 32'h8000_0002);
        check("longack.count", 32'(count), 32'h2);
        cycle(0, '0, 0);
        cycle(0, '0, 1);
        check("reack.mbox", mbox_out, 32'h8000_0003);
        cycle(0, '0, 0);
        cycle(0, '0, 1);
        check_state("drain3");
        cycle(0, '0, 0);

        // Fill, then offer a 17th while ack rises in the same cycle
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1, DATA_W'(32'h100 + i), 0);
            check_state("fill");
        end
        check("full.ready", 32'(meta_ready), 32'h0);
        cycle(1, 31'h1FF, 1);
        check("full.count", 32'(count), 32'd15);
        check("full.ovf", 32'(overflow), 32'h1);
        check("full.mbox", mbox_out, 32'h8000_0101);
`ifdef MBOX_STATS_EN
        check("full.drops", 32'(stat_drops), 32'h1);
        check("full.hiwater", 32'(stat_hiwater), 32'd16);
`endif
        check_state("full");
        for (int i = 0; i < DEPTH - 1; i++) begin
            cycle(0, '0, 0);
            cycle(0, '0, 1);
            check_state("drainfull");
        end
        cycle(0, '0, 0);

        // Ack while empty is ignored
        for (int i = 0; i < 3; i++) begin
            cycle(0, '0, 1);
            check_state("emptyack");
            cycle(0, '0, 0);
        end
        check("emptyack.count", 32'(count), 32'h0);
        cycle(1, 31'h7, 0);
        check("after_empty.mbox", mbox_out, 32'h8000_0007);

        // Reset mid-operation
        for (int i = 0; i < 5; i++) cycle(1, DATA_W'(32'h20 + i), 0);
        check_state("prereset");
        reset = 1'b1;
        cycle(0, '0, 0);
        reset = 1'b0;
        check("midrst.count", 32'(count), 32'h0);
        check("midrst.mbox", mbox_out, 32'h0);
        check("midrst.ovf", 32'(overflow), 32'h0);
        check_state("midrst");
        cycle(1, 31'h55, 0);
        check("postrst.mbox", mbox_out, 32'h8000_0055);

        // Wrap: alternating push-only and simultaneous push+pop
        for (int i = 0; i < 40; i++) begin
            cycle(1, DATA_W'(32'h1000 + 2 * i), 0);
            check_state("wrap.push");
            cycle(1, DATA_W'(32'h1001 + 2 * i), 1);
            check_state("wrap.pushpop");
            cycle(0, '0, 0);
            cycle(0, '0, 1);
            check_state("wrap.pop");
        end
        while (model_q.size() != 0 && n_total < 5000) begin
            cycle(0, '0, 0);
            cycle(0, '0, 1);
            check_state("wrap.drain");
        end
        check("final.count", 32'(count), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
